// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read port and sticky error flags.
// Latency: write-to-COUNT 1 cycle; read data 1 cycle after RD_EN (FWFT=0) or presented immediately (FWFT=1).
// Backpressure: writes while FULL are dropped unless a read pops the same cycle; reads while EMPTY are rejected.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [WIDTH-1:0]         BUFFER_IN,
    input  logic                     WR_EN,
    input  logic                     RD_EN,
    input  logic                     CLR_ERR,
    output logic [WIDTH-1:0]         BUFFER_OUT,
    output logic                     VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic empty, full, rd_ok, wr_ok;
    logic ovf_set, unf_set;

    // Status flags decode registered COUNT only, so they never depend on this cycle's requests.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign rd_ok   = RD_EN && !empty;
    assign wr_ok   = WR_EN && (!full || RD_EN);
    assign ovf_set = WR_EN && full && !RD_EN;
    assign unf_set = RD_EN && empty;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // A new error event in the same cycle as CLR_ERR keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end else if (CLR_ERR) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= BUFFER_IN;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is only ever read once it has been written, so no X escapes the unreset memory.
            assign BUFFER_OUT = empty ? '0 : mem[rd_ptr_q];
            assign VALID      = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             vld_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_ok;
                    if (rd_ok) begin
                        dout_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign BUFFER_OUT = dout_q;
            assign VALID      = vld_q;
        end
    endgenerate

    assign EMPTY        = empty;
    assign FULL         = full;
    assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));
    assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench: a = DEPTH 4 standard read, b = DEPTH 4 fall-through, c = DEPTH 16 thresholds.
module tb_fifo_param;

    logic CLK;
    logic RST_N;

    logic       a_wr, a_rd, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_vld, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [2:0] a_cnt;

    logic       b_wr, b_rd, b_clr;
    logic [7:0] b_din, b_dout;
    logic       b_vld, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [2:0] b_cnt;

    logic       c_wr, c_rd, c_clr;
    logic [7:0] c_din, c_dout;
    logic       c_vld, c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
    logic [4:0] c_cnt;

    int total = 0;
    int bad   = 0;

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b0)) u_a (
        .CLK(CLK), .RST_N(RST_N), .BUFFER_IN(a_din), .WR_EN(a_wr), .RD_EN(a_rd), .CLR_ERR(a_clr),
        .BUFFER_OUT(a_dout), .VALID(a_vld), .EMPTY(a_empty), .FULL(a_full),
        .ALMOST_EMPTY(a_ae), .ALMOST_FULL(a_af), .COUNT(a_cnt), .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
    );

    fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_b (
        .CLK(CLK), .RST_N(RST_N), .BUFFER_IN(b_din), .WR_EN(b_wr), .RD_EN(b_rd), .CLR_ERR(b_clr),
        .BUFFER_OUT(b_dout), .VALID(b_vld), .EMPTY(b_empty), .FULL(b_full),
        .ALMOST_EMPTY(b_ae), .ALMOST_FULL(b_af), .COUNT(b_cnt), .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
    );

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_c (
        .CLK(CLK), .RST_N(RST_N), .BUFFER_IN(c_din), .WR_EN(c_wr), .RD_EN(c_rd), .CLR_ERR(c_clr),
        .BUFFER_OUT(c_dout), .VALID(c_vld), .EMPTY(c_empty), .FULL(c_full),
        .ALMOST_EMPTY(c_ae), .ALMOST_FULL(c_af), .COUNT(c_cnt), .OVERFLOW(c_ovf), .UNDERFLOW(c_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of stimulus per instance; outputs are sampled 1 time unit after the edge.
    task automatic cyc_a(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
        a_wr = wr; a_rd = rd; a_din = d; a_clr = clr;
        @(posedge CLK); #1;
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    endtask

    task automatic cyc_b(input logic wr, input logic rd, input logic [7:0] d);
        b_wr = wr; b_rd = rd; b_din = d;
        @(posedge CLK); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic cyc_c(input logic wr, input logic rd, input logic [7:0] d);
        c_wr = wr; c_rd = rd; c_din = d;
        @(posedge CLK); #1;
        c_wr = 1'b0; c_rd = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (a_cnt !== 3'd0)   begin bad++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
        total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b exp 1", a_empty); end
        total++; if (a_ae !== 1'b1)    begin bad++; $display("FAIL reset_ae got %b exp 1", a_ae); end
        total++; if (a_full !== 1'b0)  begin bad++; $display("FAIL reset_full got %b exp 0", a_full); end
        total++; if (a_af !== 1'b0)    begin bad++; $display("FAIL reset_af got %b exp 0", a_af); end
        total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got %h exp 00", a_dout); end
        total++; if (a_vld !== 1'b0)   begin bad++; $display("FAIL reset_valid got %b exp 0", a_vld); end
        total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("FAIL reset_err got %b%b exp 00", a_ovf, a_unf); end
        total++; if (b_dout !== 8'h00 || b_vld !== 1'b0) begin bad++; $display("FAIL reset_fwft got %h/%b exp 00/0", b_dout, b_vld); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++; if (a_cnt !== 3'd0 || a_empty !== 1'b1 || a_vld !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got cnt=%0d empty=%b vld=%b exp 0/1/0", a_cnt, a_empty, a_vld);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, exp_q[i], 1'b0);
        total++; if (a_full !== 1'b1 || a_cnt !== 3'd4) begin bad++; $display("FAIL fill_full got full=%b cnt=%0d exp 1/4", a_full, a_cnt); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got %b exp 0", a_ovf); end
        cyc_a(1'b1, 1'b0, 8'h55, 1'b0);
        total++; if (a_ovf !== 1'b1 || a_cnt !== 3'd4) begin bad++; $display("FAIL overflow got ovf=%b cnt=%0d exp 1/4", a_ovf, a_cnt); end
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
            total++; if (a_dout !== exp_q[i] || a_vld !== 1'b1) begin
                bad++; $display("FAIL drain_%0d got %h/%b exp %h/1", i, a_dout, a_vld, exp_q[i]);
            end
        end
        total++; if (a_empty !== 1'b1 || a_cnt !== 3'd0) begin bad++; $display("FAIL drain_empty got empty=%b cnt=%0d exp 1/0", a_empty, a_cnt); end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        total++; if (a_vld !== 1'b0 || a_dout !== 8'h44) begin bad++; $display("FAIL idle_hold got %h/%b exp 44/0", a_dout, a_vld); end
        total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b exp 1", a_ovf); end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b exp 0", a_ovf); end
    endtask

    task automatic test_full_rw_wrap();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hB0;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        cyc_a(1'b1, 1'b1, 8'hB0, 1'b0);
        total++; if (a_dout !== 8'hA0 || a_vld !== 1'b1) begin bad++; $display("FAIL full_rw_data got %h/%b exp a0/1", a_dout, a_vld); end
        total++; if (a_cnt !== 3'd4 || a_ovf !== 1'b0) begin bad++; $display("FAIL full_rw_count got cnt=%0d ovf=%b exp 4/0", a_cnt, a_ovf); end
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
            total++; if (a_dout !== exp_q[i]) begin bad++; $display("FAIL wrap_%0d got %h exp %h", i, a_dout, exp_q[i]); end
        end
        total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_empty_both();
        cyc_a(1'b1, 1'b1, 8'h5A, 1'b0);
        total++; if (a_cnt !== 3'd1 || a_unf !== 1'b1 || a_vld !== 1'b0) begin
            bad++; $display("FAIL empty_both got cnt=%0d unf=%b vld=%b exp 1/1/0", a_cnt, a_unf, a_vld);
        end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        total++; if (a_unf !== 1'b0) begin bad++; $display("FAIL unf_clear got %b exp 0", a_unf); end
        cyc_a(1'b0, 1'b1, 8'h00, 1'b0);
        total++; if (a_dout !== 8'h5A || a_vld !== 1'b1) begin bad++; $display("FAIL empty_both_read got %h/%b exp 5a/1", a_dout, a_vld); end
        cyc_a(1'b0, 1'b1, 8'h00, 1'b1);
        total++; if (a_unf !== 1'b1 || a_vld !== 1'b0) begin bad++; $display("FAIL set_beats_clear got unf=%b vld=%b exp 1/0", a_unf, a_vld); end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        total++; if (a_unf !== 1'b0) begin bad++; $display("FAIL unf_clear2 got %b exp 0", a_unf); end
    endtask

    task automatic test_fwft();
        cyc_b(1'b1, 1'b0, 8'h3C);
        total++; if (b_dout !== 8'h3C || b_vld !== 1'b1 || b_empty !== 1'b0) begin
            bad++; $display("FAIL fwft_present got %h/%b/%b exp 3c/1/0", b_dout, b_vld, b_empty);
        end
        cyc_b(1'b0, 1'b0, 8'h00);
        total++; if (b_dout !== 8'h3C || b_vld !== 1'b1) begin bad++; $display("FAIL fwft_hold got %h/%b exp 3c/1", b_dout, b_vld); end
        cyc_b(1'b0, 1'b1, 8'h00);
        total++; if (b_empty !== 1'b1 || b_dout !== 8'h00 || b_vld !== 1'b0) begin
            bad++; $display("FAIL fwft_pop got %b/%h/%b exp 1/00/0", b_empty, b_dout, b_vld);
        end
        cyc_b(1'b1, 1'b0, 8'h01);
        cyc_b(1'b1, 1'b0, 8'h02);
        cyc_b(1'b0, 1'b1, 8'h00);
        total++; if (b_dout !== 8'h02 || b_cnt !== 3'd1) begin bad++; $display("FAIL fwft_next got %h/%0d exp 02/1", b_dout, b_cnt); end
    endtask

    task automatic test_thresholds();
        for (int i = 1; i <= 16; i++) begin
            cyc_c(1'b1, 1'b0, 8'(i));
            total++; if (c_cnt !== 5'(i)) begin bad++; $display("FAIL thr_count_%0d got %0d exp %0d", i, c_cnt, i); end
            total++; if (c_ae !== (i <= 2)) begin bad++; $display("FAIL thr_ae_%0d got %b exp %b", i, c_ae, (i <= 2)); end
            total++; if (c_af !== (i >= 14)) begin bad++; $display("FAIL thr_af_%0d got %b exp %b", i, c_af, (i >= 14)); end
        end
        total++; if (c_full !== 1'b1) begin bad++; $display("FAIL thr_full got %b exp 1", c_full); end
        for (int i = 0; i < 6; i++) cyc_c(1'b0, 1'b1, 8'h00);
        total++; if (c_cnt !== 5'd10 || c_dout !== 8'h06) begin bad++; $display("FAIL thr_at10 got %0d/%h exp 10/06", c_cnt, c_dout); end
        #3;
        RST_N = 1'b0;
        #1;
        total++; if (c_cnt !== 5'd0 || c_empty !== 1'b1 || c_vld !== 1'b0) begin
            bad++; $display("FAIL async_reset got cnt=%0d empty=%b vld=%b exp 0/1/0", c_cnt, c_empty, c_vld);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        cyc_c(1'b0, 1'b1, 8'h00);
        total++; if (c_unf !== 1'b1 || c_cnt !== 5'd0) begin bad++; $display("FAIL post_reset_empty got unf=%b cnt=%0d exp 1/0", c_unf, c_cnt); end
    endtask

    initial begin
        RST_N = 1'b0;
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = 8'h00;
        b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = 8'h00;
        c_wr = 1'b0; c_rd = 1'b0; c_clr = 1'b0; c_din = 8'h00;
        test_reset();
        test_fill_drain();
        test_full_rw_wrap();
        test_empty_both();
        test_fwft();
        test_thresholds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that supersedes the fixed 8x8 streaming buffer. Width, depth and almost-full/almost-empty thresholds are configurable, and a first-word-fall-through (FWFT) read mode is selectable. Adds simultaneous read+write while full, sticky overflow/underflow error flags and an output-valid strobe. Sits between streaming producers and consumers in the IO path, in a single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=2
AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read with 1-cycle latency; 1 = head word presented without a read request

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
BUFFER_IN  in  WIDTH  write data
WR_EN  in  1  write request
RD_EN  in  1  read (pop) request
CLR_ERR  in  1  synchronous clear of OVERFLOW/UNDERFLOW
BUFFER_OUT  out  WIDTH  read data
VALID  out  1  BUFFER_OUT holds valid data (see Behaviour)
EMPTY  out  1  COUNT == 0
FULL  out  1  COUNT == DEPTH
ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
COUNT  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: a write was dropped
UNDERFLOW  out  1  sticky: a read was rejected

Behaviour:
- Reset (RST_N low, async):
  - COUNT, read/write pointers, BUFFER_OUT, VALID, OVERFLOW and UNDERFLOW all 0.
  - EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Acceptance rules, evaluated per rising edge on registered state:
  - rd_ok = RD_EN && !EMPTY
  - wr_ok = WR_EN && (!FULL || RD_EN)
  - Full with both requests: pop and push both occur; COUNT stays DEPTH; the read returns the old head.
  - Empty with both requests: push only; read rejected.
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged on both or neither.
  - Never leaves the range 0..DEPTH.
- Pointers:
  - Width log2(DEPTH); wr_ptr advances on wr_ok, rd_ptr advances on rd_ok.
  - Both wrap modulo DEPTH.
  - Memory write at mem[wr_ptr] on wr_ok.
- Flags: EMPTY, FULL, ALMOST_* are combinational decodes of registered COUNT only, so no combinational path from WR_EN/RD_EN.
- Errors:
  - OVERFLOW sets on WR_EN && FULL && !RD_EN (write dropped).
  - UNDERFLOW sets on RD_EN && EMPTY.
  - Both hold until an edge with CLR_ERR=1 and no new error event; if set and clear occur in the same cycle, set wins.
- FWFT=0 (standard mode):
  - On rd_ok, BUFFER_OUT <= mem[rd_ptr] at that edge; VALID=1 for exactly the following cycle.
  - Otherwise BUFFER_OUT holds its last value and VALID=0.
- FWFT=1 (fall-through mode):
  - BUFFER_OUT = mem[rd_ptr] whenever !EMPTY, else 0.
  - VALID = !EMPTY.
  - RD_EN acknowledges and pops the presented word.
  - A word written into an empty FIFO appears on BUFFER_OUT the cycle after its write edge.
- Outputs are X-free after reset in both modes.

Test Plan:
- Reset/idle (WIDTH=8, DEPTH=4): hold RST_N=0 then release -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, BUFFER_OUT=0, VALID=0, OVERFLOW=0, UNDERFLOW=0.
- Fill/drain, FWFT=0: write 0x11,0x22,0x33,0x44, then 5th write 0x55 -> FULL=1, COUNT=4, OVERFLOW=1. Read 4 times -> BUFFER_OUT 0x11,0x22,0x33,0x44, each one cycle after its RD_EN with VALID=1; EMPTY=1 at end.
- Read-while-full and wrap: from full {0xA0..0xA3}, assert WR_EN+RD_EN with 0xB0 -> BUFFER_OUT=0xA0, COUNT stays 4. Drain -> 0xA1,0xA2,0xA3,0xB0, exercising pointer wrap.
- Empty with both requests: from empty, WR_EN+RD_EN with 0x5A -> COUNT=1, UNDERFLOW=1, VALID=0. Pulse CLR_ERR -> UNDERFLOW=0. Next read returns 0x5A.
- FWFT=1: write 0x3C into empty -> next cycle BUFFER_OUT=0x3C, VALID=1 with no RD_EN. Pulse RD_EN -> EMPTY=1, BUFFER_OUT=0, VALID=0.
- Thresholds and mid-operation reset (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2): ALMOST_EMPTY deasserts at COUNT=3; ALMOST_FULL asserts at COUNT=14. Assert RST_N=0 at COUNT=10 -> COUNT=0 immediately without waiting for a clock edge.
